// File: rtl/alu_pkg.sv
// Shared opcode encodings and constants for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned SIZEOP_DEF = 6;

  typedef enum logic [SIZEOP_DEF-1:0] {
    OP_SRL = 6'b000010,
    OP_SRA = 6'b000011,
    OP_ADD = 6'b100000,
    OP_SUB = 6'b100010,
    OP_AND = 6'b100100,
    OP_OR  = 6'b100101,
    OP_XOR = 6'b100110,
    OP_NOR = 6'b100111
  } alu_op_e;

  // An undefined opcode yields an all-zero result with ZERO asserted.
  localparam logic UNDEF_ZERO     = 1'b1;
  localparam logic UNDEF_CARRY    = 1'b0;
  localparam logic UNDEF_OVERFLOW = 1'b0;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU core: next result and flags from operands and opcode.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int unsigned SIZEDATA = 8,
  parameter int unsigned SIZEOP   = SIZEOP_DEF
) (
  input  logic [SIZEDATA-1:0] DATOA,
  input  logic [SIZEDATA-1:0] DATOB,
  input  logic [SIZEOP-1:0]   OPCODE,
  output logic [SIZEDATA-1:0] result,
  output logic                zero,
  output logic                carry,
  output logic                overflow
);

  localparam int unsigned     MSB         = SIZEDATA - 1;
  localparam logic [SIZEDATA:0] SHIFT_LIMIT = (SIZEDATA + 1)'(SIZEDATA);

  logic [SIZEDATA:0] sum;
  logic [SIZEDATA:0] diff;
  logic              shift_oob;
  logic              undef_op;

  // Extra top bit holds the unsigned carry-out / borrow.
  assign sum       = {1'b0, DATOA} + {1'b0, DATOB};
  assign diff      = {1'b0, DATOA} - {1'b0, DATOB};
  assign shift_oob = ({1'b0, DATOB} >= SHIFT_LIMIT);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    undef_op = 1'b0;
    case (OPCODE)
      SIZEOP'(OP_ADD): begin
        result   = sum[MSB:0];
        carry    = sum[SIZEDATA];
        overflow = (DATOA[MSB] == DATOB[MSB]) && (sum[MSB] != DATOA[MSB]);
      end
      SIZEOP'(OP_SUB): begin
        result   = diff[MSB:0];
        carry    = diff[SIZEDATA];
        overflow = (DATOA[MSB] != DATOB[MSB]) && (diff[MSB] != DATOA[MSB]);
      end
      SIZEOP'(OP_AND): result = DATOA & DATOB;
      SIZEOP'(OP_OR):  result = DATOA | DATOB;
      SIZEOP'(OP_XOR): result = DATOA ^ DATOB;
      SIZEOP'(OP_NOR): result = ~(DATOA | DATOB);
      SIZEOP'(OP_SRL): result = shift_oob ? '0 : (DATOA >> DATOB);
      SIZEOP'(OP_SRA): result = shift_oob ? {SIZEDATA{DATOA[MSB]}}
                                          : SIZEDATA'($signed(DATOA) >>> DATOB);
      default: begin
        undef_op = 1'b1;
        carry    = UNDEF_CARRY;
        overflow = UNDEF_OVERFLOW;
      end
    endcase
  end

  assign zero = undef_op ? UNDEF_ZERO : (result == '0);

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: registered result, flags and valid, one cycle latency.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned SIZEDATA = 8,
  parameter int unsigned SIZEOP   = SIZEOP_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                VALID_IN,
  input  logic [SIZEDATA-1:0] DATOA,
  input  logic [SIZEDATA-1:0] DATOB,
  input  logic [SIZEOP-1:0]   OPCODE,
  output logic [SIZEDATA-1:0] RESULT,
  output logic                ZERO,
  output logic                CARRY,
  output logic                OVERFLOW,
  output logic                VALID_OUT
);

  logic [SIZEDATA-1:0] nxt_result;
  logic                nxt_zero;
  logic                nxt_carry;
  logic                nxt_overflow;

  alu_datapath #(
    .SIZEDATA (SIZEDATA),
    .SIZEOP   (SIZEOP)
  ) u_datapath (
    .DATOA    (DATOA),
    .DATOB    (DATOB),
    .OPCODE   (OPCODE),
    .result   (nxt_result),
    .zero     (nxt_zero),
    .carry    (nxt_carry),
    .overflow (nxt_overflow)
  );

  // Result and flags only update on a valid edge; VALID_OUT tracks every edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RESULT    <= '0;
      ZERO      <= 1'b0;
      CARRY     <= 1'b0;
      OVERFLOW  <= 1'b0;
      VALID_OUT <= 1'b0;
    end else begin
      VALID_OUT <= VALID_IN;
      if (VALID_IN) begin
        RESULT   <= nxt_result;
        ZERO     <= nxt_zero;
        CARRY    <= nxt_carry;
        OVERFLOW <= nxt_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard of expected outputs per issued op.
module tb_alu;

  localparam logic [5:0] T_ADD = 6'b100000;
  localparam logic [5:0] T_SUB = 6'b100010;
  localparam logic [5:0] T_AND = 6'b100100;
  localparam logic [5:0] T_OR  = 6'b100101;
  localparam logic [5:0] T_XOR = 6'b100110;
  localparam logic [5:0] T_NOR = 6'b100111;
  localparam logic [5:0] T_SRL = 6'b000010;
  localparam logic [5:0] T_SRA = 6'b000011;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       o;
    logic       v;
  } exp_t;

  typedef struct packed {
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       o;
  } vec_t;

  logic       CLK;
  logic       RST_N;
  logic       VALID_IN;
  logic [7:0] DATOA;
  logic [7:0] DATOB;
  logic [5:0] OPCODE;
  logic [7:0] RESULT;
  logic       ZERO;
  logic       CARRY;
  logic       OVERFLOW;
  logic       VALID_OUT;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  alu #(
    .SIZEDATA (8),
    .SIZEOP   (6)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .VALID_IN  (VALID_IN),
    .DATOA     (DATOA),
    .DATOB     (DATOB),
    .OPCODE    (OPCODE),
    .RESULT    (RESULT),
    .ZERO      (ZERO),
    .CARRY     (CARRY),
    .OVERFLOW  (OVERFLOW),
    .VALID_OUT (VALID_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t observed();
    exp_t g;
    g.r = RESULT;
    g.z = ZERO;
    g.c = CARRY;
    g.o = OVERFLOW;
    g.v = VALID_OUT;
    return g;
  endfunction

  // Integer reference model, independent of the RTL's carry-bit formulation.
  function automatic exp_t model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t        e;
    int          sa;
    int          sb;
    int          s;
    int unsigned ua;
    int unsigned ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    e  = '0;
    e.v = 1'b1;
    case (op)
      T_ADD: begin s = sa + sb; e.r = 8'(ua + ub); e.c = (ua + ub) > 255; e.o = (s > 127) || (s < -128); end
      T_SUB: begin s = sa - sb; e.r = 8'(ua - ub); e.c = ua < ub;         e.o = (s > 127) || (s < -128); end
      T_AND: e.r = a & b;
      T_OR:  e.r = a | b;
      T_XOR: e.r = a ^ b;
      T_NOR: e.r = ~(a | b);
      T_SRL: e.r = (ub >= 8) ? 8'h00 : 8'(ua >> ub);
      T_SRA: e.r = 8'(sa >>> ((ub > 7) ? 7 : ub));
      default: e.r = 8'h00;
    endcase
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    VALID_IN = v;
    OPCODE   = op;
    DATOA    = a;
    DATOB    = b;
  endtask

  task automatic test_reset();
    exp_t g;
    RST_N    = 1'b0;
    VALID_IN = 1'b0;
    OPCODE   = '0;
    DATOA    = '0;
    DATOB    = '0;
    #3;
    g = observed();
    checks++;
    if (g !== exp_t'(0)) begin
      failures++;
      $display("FAIL reset: got %h want %h", g, exp_t'(0));
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic run_table(input string name, input vec_t tv[]);
    exp_t e;
    exp_t g;
    foreach (tv[i]) begin
      drive(1'b1, tv[i].op, tv[i].a, tv[i].b);
      exp_q.push_back('{r: tv[i].r, z: tv[i].z, c: tv[i].c, o: tv[i].o, v: 1'b1});
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL %s[%0d] op=%b a=%h b=%h: got r=%h z=%b c=%b o=%b v=%b want r=%h z=%b c=%b o=%b v=%b",
                 name, i, tv[i].op, tv[i].a, tv[i].b, g.r, g.z, g.c, g.o, g.v, e.r, e.z, e.c, e.o, e.v);
      end
    end
  endtask

  task automatic test_arith();
    vec_t tv[];
    tv = new[7];
    tv[0] = '{T_ADD, 8'd7,   8'd2,   8'h09, 1'b0, 1'b0, 1'b0};
    tv[1] = '{T_SUB, 8'd7,   8'd2,   8'h05, 1'b0, 1'b0, 1'b0};
    tv[2] = '{T_ADD, 8'd127, 8'd1,   8'h80, 1'b0, 1'b0, 1'b1};
    tv[3] = '{T_SUB, 8'd0,   8'd1,   8'hFF, 1'b0, 1'b1, 1'b0};
    tv[4] = '{T_SUB, 8'hFB,  8'hFB,  8'h00, 1'b1, 1'b0, 1'b0};
    tv[5] = '{T_ADD, 8'hFF,  8'h01,  8'h00, 1'b1, 1'b1, 1'b0};
    tv[6] = '{T_SUB, 8'h80,  8'h01,  8'h7F, 1'b0, 1'b0, 1'b1};
    run_table("arith", tv);
  endtask

  task automatic test_logic();
    vec_t tv[];
    tv = new[4];
    tv[0] = '{T_AND, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 1'b0};
    tv[1] = '{T_OR,  8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0, 1'b0};
    tv[2] = '{T_XOR, 8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0, 1'b0};
    tv[3] = '{T_NOR, 8'hC3, 8'h5A, 8'h24, 1'b0, 1'b0, 1'b0};
    run_table("logic", tv);
  endtask

  task automatic test_shift();
    vec_t tv[];
    tv = new[10];
    tv[0] = '{T_SRA, 8'h80, 8'd3,   8'hF0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{T_SRL, 8'h80, 8'd3,   8'h10, 1'b0, 1'b0, 1'b0};
    tv[2] = '{T_SRA, 8'h80, 8'd9,   8'hFF, 1'b0, 1'b0, 1'b0};
    tv[3] = '{T_SRL, 8'h80, 8'd9,   8'h00, 1'b1, 1'b0, 1'b0};
    tv[4] = '{T_SRA, 8'h80, 8'd8,   8'hFF, 1'b0, 1'b0, 1'b0};
    tv[5] = '{T_SRL, 8'h80, 8'd7,   8'h01, 1'b0, 1'b0, 1'b0};
    tv[6] = '{T_SRL, 8'h80, 8'd0,   8'h80, 1'b0, 1'b0, 1'b0};
    tv[7] = '{T_SRA, 8'h7F, 8'd9,   8'h00, 1'b1, 1'b0, 1'b0};
    tv[8] = '{T_SRA, 8'h80, 8'h80,  8'hFF, 1'b0, 1'b0, 1'b0};
    tv[9] = '{T_SRL, 8'hFF, 8'h80,  8'h00, 1'b1, 1'b0, 1'b0};
    run_table("shift", tv);
  endtask

  task automatic test_undef();
    vec_t tv[];
    tv = new[3];
    tv[0] = '{T_ADD,    8'd7,   8'd1,   8'h08, 1'b0, 1'b0, 1'b0};
    tv[1] = '{6'b111111, 8'hAA, 8'h55,  8'h00, 1'b1, 1'b0, 1'b0};
    tv[2] = '{6'b000000, 8'h80, 8'h80,  8'h00, 1'b1, 1'b0, 1'b0};
    run_table("undef", tv);
  endtask

  task automatic test_hold();
    exp_t e;
    exp_t g;
    drive(1'b1, T_ADD, 8'd127, 8'd1);
    exp_q.push_back('{r: 8'h80, z: 1'b0, c: 1'b0, o: 1'b1, v: 1'b1});
    for (int unsigned k = 0; k < 3; k++) begin
      if (k != 0) begin
        drive(1'b0, (k == 1) ? T_SUB : T_AND, 8'h55 + 8'(k), 8'h11);
        exp_q.push_back('{r: 8'h80, z: 1'b0, c: 1'b0, o: 1'b1, v: 1'b0});
      end
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL hold[%0d]: got r=%h z=%b c=%b o=%b v=%b want r=%h z=%b c=%b o=%b v=%b",
                 k, g.r, g.z, g.c, g.o, g.v, e.r, e.z, e.c, e.o, e.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[9];
    exp_t       last;
    exp_t       e;
    exp_t       g;
    logic       v;
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    ops  = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR, T_SRL, T_SRA, 6'b010101};
    last = '0;
    for (int unsigned n = 0; n < 40; n++) begin
      v  = (n == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      op = ops[$urandom_range(0, 8)];
      a  = 8'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      drive(v, op, a, b);
      if (v) last = model(op, a, b);
      last.v = v;
      exp_q.push_back(last);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b2b[%0d] v=%b op=%b a=%h b=%h: got r=%h z=%b c=%b o=%b v=%b want r=%h z=%b c=%b o=%b v=%b",
                 n, v, op, a, b, g.r, g.z, g.c, g.o, g.v, e.r, e.z, e.c, e.o, e.v);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t g;
    drive(1'b1, T_ADD, 8'd7, 8'd2);
    @(posedge CLK);
    #1;
    checks++;
    if (RESULT !== 8'h09) begin
      failures++;
      $display("FAIL rst_pre: got RESULT=%h want 09", RESULT);
    end
    // New op pending; reset arrives between edges and must discard it.
    drive(1'b1, T_SUB, 8'd0, 8'd1);
    #2;
    RST_N = 1'b0;
    #1;
    g = observed();
    checks++;
    if (g !== exp_t'(0)) begin
      failures++;
      $display("FAIL rst_async: got %h want %h", g, exp_t'(0));
    end
    @(posedge CLK);
    #1;
    g = observed();
    checks++;
    if (g !== exp_t'(0)) begin
      failures++;
      $display("FAIL rst_held: got %h want %h", g, exp_t'(0));
    end
    drive(1'b0, T_SUB, 8'd0, 8'd1);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    g = observed();
    checks++;
    if (g !== exp_t'(0)) begin
      failures++;
      $display("FAIL rst_release: got %h want %h", g, exp_t'(0));
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_undef();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterized integer ALU with registered outputs, driven by a 6-bit MIPS-style function opcode.
- Computes add, subtract, bitwise logic and right shifts on two signed operands, and flags the result.
- Sits in the execute stage. One clock cycle of latency from sampled operands to RESULT and flags.

Parameters:
- SIZEDATA, 8: operand and result width in bits (must be at least 2).
- SIZEOP, 6: opcode width in bits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- VALID_IN  input  1  high when DATOA, DATOB and OPCODE hold an operation to execute.
- DATOA  input  SIZEDATA  operand A, two's complement.
- DATOB  input  SIZEDATA  operand B, two's complement; for shifts, used as an unsigned shift amount.
- OPCODE  input  SIZEOP  operation select.
- RESULT  output  SIZEDATA  registered result.
- ZERO  output  1  registered; set when the result is all zeros.
- CARRY  output  1  registered; ADD gives the unsigned carry-out, SUB gives the unsigned borrow (A<B); 0 for all other operations.
- OVERFLOW  output  1  registered; signed overflow for ADD/SUB; 0 for all other operations.
- VALID_OUT  output  1  registered copy of VALID_IN.

Behaviour:
- Reset: while RST_N is low, RESULT=0, ZERO=0, CARRY=0, OVERFLOW=0 and VALID_OUT=0, applied asynchronously. Release is synchronous to CLK in use. A reset mid-operation discards the pending result.
- Opcodes:
  - ADD 6'b100000: A+B, truncated to SIZEDATA.
  - SUB 6'b100010: A-B, truncated.
  - AND 6'b100100: A&B.
  - OR 6'b100101: A|B.
  - XOR 6'b100110: A^B.
  - NOR 6'b100111: ~(A|B).
  - SRL 6'b000010: A logical right shift by B; zero fill.
  - SRA 6'b000011: A arithmetic right shift by B; sign fill.
- Shift amount is B taken as unsigned. If the amount is SIZEDATA or more: SRL gives 0; SRA gives all copies of A's sign bit.
- Undefined opcode: RESULT=0, ZERO=1, CARRY=0, OVERFLOW=0.
- OVERFLOW rules:
  - ADD: set when the operands have the same sign and the result sign differs.
  - SUB: set when the operands have different signs and the result sign differs from A.
- Timing:
  - On a rising CLK edge with VALID_IN=1: RESULT and flags load the combinational values; VALID_OUT goes to 1.
  - With VALID_IN=0: RESULT and flags hold their previous values; VALID_OUT goes to 0.
  - Back-to-back operations run one per cycle, with no stall and no backpressure.
- Operand or opcode changes between edges have no effect on the outputs until the next qualifying edge.
- Latency is exactly 1 cycle.

Decomposition:
- Package alu_pkg holds:
  - the SIZEOP default;
  - the eight opcode constants (ADD, SUB, AND, OR, XOR, NOR, SRL, SRA);
  - a function or constant for the "undefined opcode" result.
- One sub-module, alu_datapath, is purely combinational. It maps DATOA, DATOB and OPCODE to a next result and next flags, and contains no state.
- The top-level alu instantiates alu_datapath and holds the output registers, the VALID pipeline bit and the reset logic.

Test Plan:
- ADD: A=7, B=2, VALID_IN=1 -> one cycle later RESULT=9, ZERO=0, CARRY=0, OVERFLOW=0, VALID_OUT=1. Then SUB with the same operands -> RESULT=5.
- ADD overflow: A=127, B=1 -> RESULT=8'h80 (-128), OVERFLOW=1, CARRY=0.
- SUB borrow: A=0, B=1 -> RESULT=8'hFF, CARRY=1, OVERFLOW=0.
- SUB zero: A=B=-5 -> RESULT=0, ZERO=1.
- Logic ops with A=8'hC3, B=8'h5A -> AND=8'h42, OR=8'hDB, XOR=8'h99, NOR=8'h24, all with CARRY=0 and OVERFLOW=0.
- Shifts with A=8'h80:
  - B=3: SRA gives 8'hF0, SRL gives 8'h10.
  - B=9: SRA gives 8'hFF, SRL gives 8'h00 with ZERO=1.
- Undefined opcode 6'b111111 -> RESULT=0, ZERO=1.
- Hold: VALID_IN=0 with changed operands -> RESULT is held and VALID_OUT=0.
- Reset: assert RST_N=0 mid-stream, off a clock edge -> all outputs drop to 0 immediately.
